// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    WR   = 3'd4,
    REL  = 3'd5,
    GAP  = 3'd6
  } dma_state_t;

  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DST   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;

endpackage

// File: rtl/dma_regs.sv
// CPU-visible SRC/DST/COUNT registers and CTRL strobe decode.
// Every write is locked out while a transfer is in progress.
module dma_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              busy,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [CNT_W-1:0]  count,
  output logic              start,
  output logic              clr_done
);

  logic wr_ok;

  assign wr_ok = cfg_we && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src   <= '0;
      dst   <= '0;
      count <= '0;
    end else if (wr_ok) begin
      unique case (cfg_addr)
        REG_SRC:   src   <= ADDR_W'(cfg_wdata);
        REG_DST:   dst   <= ADDR_W'(cfg_wdata);
        REG_COUNT: count <= CNT_W'(cfg_wdata);
        default:   ;
      endcase
    end
  end

  // CTRL is not stored: its bits act as single-cycle command strobes.
  assign start    = wr_ok && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_START_BIT];
  assign clr_done = wr_ok && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_CLR_DONE_BIT];

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA engine arbitrating the bus with hold/hlda.
// Define DMA_CYCLE_STEAL_EN to hand the bus back to the CPU between bytes instead of bursting.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              hold,
  input  logic              hlda,
  output logic              bus_own,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] DB,
  output logic              MemRead,
  output logic              Enable,
  output logic              busy,
  output logic              done
);

  dma_state_t        state, state_next;
  logic [ADDR_W-1:0] src_cfg, dst_cfg;
  logic [CNT_W-1:0]  cnt_cfg;
  logic              start, clr_done;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q, done_q;
  logic              db_oe;
  logic              last_byte;

  dma_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy_q),
    .src       (src_cfg),
    .dst       (dst_cfg),
    .count     (cnt_cfg),
    .start     (start),
    .clr_done  (clr_done)
  );

  assign last_byte = (cnt_q == CNT_W'(1));

  // Bus handshake: hold is raised in REQ and kept for the whole byte; hlda is
  // only sampled at posedge. A grant withdrawn mid-byte is honoured after that
  // byte's WR, returning to REQ with hold still asserted.
`ifndef DMA_CYCLE_STEAL_EN
  logic lost_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q <= 1'b0;
    end else if (state == WR) begin
      lost_q <= 1'b0;
    end else if ((state == RD || state == CAP) && !hlda) begin
      lost_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start && cnt_cfg != '0) state_next = REQ;
      REQ:  if (hlda) state_next = RD;
      RD:   state_next = CAP;
      CAP:  state_next = WR;
      WR: begin
        if (last_byte) begin
          state_next = REL;
        end else begin
`ifdef DMA_CYCLE_STEAL_EN
          state_next = GAP;
`else
          state_next = (!hlda || lost_q) ? REQ : RD;
`endif
        end
      end
      REL:     state_next = IDLE;
      GAP:     state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hold    = 1'b0;
    bus_own = 1'b0;
    Enable  = 1'b0;
    MemRead = 1'b0;
    Address = addr_q;
    db_oe   = 1'b0;
    unique case (state)
      REQ: hold = 1'b1;
      RD, CAP: begin
        hold    = 1'b1;
        bus_own = 1'b1;
        Enable  = 1'b1;
        MemRead = 1'b1;
        Address = src_q;
      end
      WR: begin
        hold    = 1'b1;
        bus_own = 1'b1;
        Enable  = 1'b1;
        Address = dst_q;
        db_oe   = 1'b1;
      end
      default: ;
    endcase
  end

  assign DB   = db_oe ? data_q : 'z;
  assign busy = busy_q;
  assign done = done_q;

  // Working copies advance during the transfer; the CPU registers stay untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= Address;
      unique case (state)
        IDLE: begin
          if (clr_done) done_q <= 1'b0;
          if (start) begin
            if (cnt_cfg == '0) begin
              done_q <= 1'b1;
            end else begin
              src_q  <= src_cfg;
              dst_q  <= dst_cfg;
              cnt_q  <= cnt_cfg;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end
        end
        CAP: begin
          data_q <= DB;
          src_q  <= src_q + ADDR_W'(1);
        end
        WR: begin
          dst_q <= dst_q + ADDR_W'(1);
          cnt_q <= cnt_q - CNT_W'(1);
        end
        REL: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
